// File: rtl/fft_pkg.sv
// Shared types and constants for the pipelined FFT datapath.
package fft_pkg;

  localparam int DATA_W = 24;
  localparam int FRAC   = 8;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Stage timebase driven by the twiddle ROM; code 3 behaves like idle.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_BFLY = 2'd2;

endpackage

// File: rtl/cmul_q.sv
// Combinational Q-format complex multiplier: full-precision products,
// round-half-up by adding 2^(FRAC-1), arithmetic shift, wrap to DATA_W.
module cmul_q #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int FRAC   = fft_pkg::FRAC
) (
  input  logic signed [DATA_W-1:0] a_r,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_r,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] p_r,
  output logic signed [DATA_W-1:0] p_i
);

  localparam int PW = 2 * DATA_W;
  localparam int AW = PW + 1;
  localparam logic signed [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);

  function automatic logic signed [DATA_W-1:0] round_q(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] t;
    t = (acc + RND) >>> FRAC;
    return t[DATA_W-1:0];
  endfunction

  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [AW-1:0] acc_r, acc_i;

  assign rr = PW'(a_r) * PW'(b_r);
  assign ii = PW'(a_i) * PW'(b_i);
  assign ri = PW'(a_r) * PW'(b_i);
  assign ir = PW'(a_i) * PW'(b_r);

  // One guard bit keeps the product sum exact before rounding.
  assign acc_r = $signed({rr[PW-1], rr}) - $signed({ii[PW-1], ii});
  assign acc_i = $signed({ri[PW-1], ri}) + $signed({ir[PW-1], ir});

  assign p_r = round_q(acc_r);
  assign p_i = round_q(acc_i);

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: feedback delay line,
// sum/difference butterfly, twiddle on drain, one registered output stage.
module sdf_r2_stage #(
  parameter int DELAY  = 2,
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int FRAC   = fft_pkg::FRAC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic [1:0]               state,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);
  import fft_pkg::*;

  // Slot 0 is the head (oldest), slot DELAY-1 the tail.
  logic signed [DATA_W-1:0] line_r [DELAY];
  logic signed [DATA_W-1:0] line_i [DELAY];
  logic [DELAY-1:0]         line_v;

  logic signed [DATA_W-1:0] h_r, h_i, x_r, x_i;
  logic signed [DATA_W-1:0] sum_r, sum_i, dif_r, dif_i, tw_r, tw_i;
  logic signed [DATA_W-1:0] tail_r, tail_i, res_r_p0, res_i_p0;
  logic                     hv, tail_v, adv, vld_p0;

  logic signed [DATA_W-1:0] dout_r_p1, dout_i_p1;
  logic                     vld_p1;

  cmul_q #(.DATA_W(DATA_W), .FRAC(FRAC)) u_cmul (
    .a_r (h_r),
    .a_i (h_i),
    .b_r (w_r),
    .b_i (w_i),
    .p_r (tw_r),
    .p_i (tw_i)
  );

  // ---- stage p0: head read, butterfly, tail selection ----
  always_comb begin
    h_r      = line_r[0];
    h_i      = line_i[0];
    hv       = line_v[0];
    x_r      = in_valid ? din_r : '0;
    x_i      = in_valid ? din_i : '0;
    sum_r    = h_r + x_r;
    sum_i    = h_i + x_i;
    dif_r    = h_r - x_r;
    dif_i    = h_i - x_i;
    adv      = 1'b0;
    vld_p0   = 1'b0;
    res_r_p0 = tw_r;
    res_i_p0 = tw_i;
    tail_r   = x_r;
    tail_i   = x_i;
    tail_v   = in_valid;
    case (state)
      ST_LOAD: begin
        adv    = 1'b1;
        vld_p0 = hv;
      end
      ST_BFLY: begin
        adv      = 1'b1;
        vld_p0   = in_valid & hv;
        res_r_p0 = sum_r;
        res_i_p0 = sum_i;
        tail_r   = dif_r;
        tail_i   = dif_i;
        tail_v   = in_valid & hv;
      end
      ST_IDLE: ;
      default: ;
    endcase
  end

  // ---- stage p1: delay-line update and output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DELAY; k++) begin
        line_r[k] <= '0;
        line_i[k] <= '0;
      end
      line_v    <= '0;
      vld_p1    <= 1'b0;
      dout_r_p1 <= '0;
      dout_i_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        dout_r_p1 <= res_r_p0;
        dout_i_p1 <= res_i_p0;
      end
      if (adv) begin
        for (int k = 0; k < DELAY - 1; k++) begin
          line_r[k] <= line_r[k+1];
          line_i[k] <= line_i[k+1];
          line_v[k] <= line_v[k+1];
        end
        line_r[DELAY-1] <= tail_r;
        line_i[DELAY-1] <= tail_i;
        line_v[DELAY-1] <= tail_v;
      end
    end
  end

  assign out_valid = vld_p1;
  assign dout_r    = dout_r_p1;
  assign dout_i    = dout_i_p1;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Directed and randomized bench for sdf_r2_stage against a queue-based
// behavioural model of the feedback delay line.
module tb_sdf_r2_stage;
  import fft_pkg::*;

  localparam int D = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic [1:0]               state;
  logic signed [23:0]       din_r, din_i, w_r, w_i;
  logic                     out_valid;
  logic signed [23:0]       dout_r, dout_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    cplx_t c;
    bit    v;
  } slot_t;

  slot_t              mq[$];
  bit                 m_v;
  logic signed [23:0] m_r, m_i;

  sdf_r2_stage #(.DELAY(D), .DATA_W(24), .FRAC(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [23:0] lo24(input longint v);
    return v[23:0];
  endfunction

  // FIFO of D complex samples: each advancing cycle pops the oldest entry
  // and pushes exactly one new entry.
  task automatic model(input bit rst, input logic [1:0] st, input bit iv,
                       input logic signed [23:0] dr, input logic signed [23:0] di,
                       input logic signed [23:0] wr, input logic signed [23:0] wi);
    slot_t  h, t;
    longint pr, pi;
    if (rst) begin
      mq.delete();
      t.c = '0;
      t.v = 1'b0;
      repeat (D) mq.push_back(t);
      m_v = 1'b0;
      m_r = '0;
      m_i = '0;
    end else if (st == 2'd1 || st == 2'd2) begin
      h      = mq.pop_front();
      t.c.re = iv ? dr : 24'sd0;
      t.c.im = iv ? di : 24'sd0;
      t.v    = iv;
      if (st == 2'd1) begin
        m_v = h.v;
        if (h.v) begin
          pr  = longint'(h.c.re) * longint'(wr) - longint'(h.c.im) * longint'(wi);
          pi  = longint'(h.c.re) * longint'(wi) + longint'(h.c.im) * longint'(wr);
          m_r = lo24((pr + 128) >>> 8);
          m_i = lo24((pi + 128) >>> 8);
        end
      end else begin
        m_v = iv & h.v;
        if (m_v) begin
          m_r = h.c.re + t.c.re;
          m_i = h.c.im + t.c.im;
        end
        t.c.re = h.c.re - t.c.re;
        t.c.im = h.c.im - t.c.im;
        t.v    = m_v;
      end
      mq.push_back(t);
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic cyc(input bit rst, input logic [1:0] st, input bit iv,
                     input logic signed [23:0] dr, input logic signed [23:0] di,
                     input logic signed [23:0] wr, input logic signed [23:0] wi);
    reset    = rst;
    state    = st;
    in_valid = iv;
    din_r    = dr;
    din_i    = di;
    w_r      = wr;
    w_i      = wi;
    @(posedge clk);
    model(rst, st, iv, dr, di, wr, wi);
    #1;
    chk("out_valid", {23'd0, out_valid}, {23'd0, m_v});
    if (m_v) begin
      chk("dout_r", dout_r, m_r);
      chk("dout_i", dout_i, m_i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; state = 2'd0; in_valid = 1'b0;
    din_r = '0; din_i = '0; w_r = '0; w_i = '0;

    // Reset held with random inputs
    repeat (3) begin
      cyc(1'b1, 2'($urandom), 1'($urandom), 24'($urandom), 24'($urandom),
          24'($urandom), 24'($urandom));
      chk("rst_v", {23'd0, out_valid}, 24'd0);
      chk("rst_dr", dout_r, 24'h000000);
      chk("rst_di", dout_i, 24'h000000);
    end
    cyc(1'b0, 2'd0, 1'b0, 0, 0, 0, 0);
    chk("post_rst_v", {23'd0, out_valid}, 24'd0);
    chk("post_rst_dr", dout_r, 24'h000000);

    // Butterfly with w = 1.0
    cyc(1'b0, 2'd1, 1'b1, 24'h000100, 0, 24'h000100, 0);
    chk("ld0_v", {23'd0, out_valid}, 24'd0);
    cyc(1'b0, 2'd1, 1'b1, 24'h000200, 0, 24'h000100, 0);
    chk("ld1_v", {23'd0, out_valid}, 24'd0);
    cyc(1'b0, 2'd2, 1'b1, 24'h000300, 0, 24'h000100, 0);
    chk("sum0", dout_r, 24'h000400);
    cyc(1'b0, 2'd2, 1'b1, 24'h000400, 0, 24'h000100, 0);
    chk("sum1", dout_r, 24'h000600);
    cyc(1'b0, 2'd1, 1'b0, 0, 0, 24'h000100, 0);
    chk("dif0", dout_r, 24'hFFFE00);
    cyc(1'b0, 2'd1, 1'b0, 0, 0, 24'h000100, 0);
    chk("dif1", dout_r, 24'hFFFE00);

    // Same run, drained through twiddle -j
    cyc(1'b0, 2'd1, 1'b1, 24'h000100, 0, 0, 24'hFFFF00);
    cyc(1'b0, 2'd1, 1'b1, 24'h000200, 0, 0, 24'hFFFF00);
    cyc(1'b0, 2'd2, 1'b1, 24'h000300, 0, 0, 24'hFFFF00);
    cyc(1'b0, 2'd2, 1'b1, 24'h000400, 0, 0, 24'hFFFF00);
    cyc(1'b0, 2'd1, 1'b0, 0, 0, 0, 24'hFFFF00);
    chk("mj0_r", dout_r, 24'h000000);
    chk("mj0_i", dout_i, 24'h000200);
    cyc(1'b0, 2'd1, 1'b0, 0, 0, 0, 24'hFFFF00);
    chk("mj1_r", dout_r, 24'h000000);
    chk("mj1_i", dout_i, 24'h000200);

    // Rounding: 3*0.5 -> 2, 1*0.5 -> 1
    cyc(1'b0, 2'd1, 1'b1, 24'h000003, 0, 24'h000080, 0);
    cyc(1'b0, 2'd1, 1'b1, 24'h000001, 0, 24'h000080, 0);
    cyc(1'b0, 2'd1, 1'b0, 0, 0, 24'h000080, 0);
    chk("rnd3", dout_r, 24'h000002);
    cyc(1'b0, 2'd1, 1'b0, 0, 0, 24'h000080, 0);
    chk("rnd1", dout_r, 24'h000001);

    // Wrap-around on the sum, stored difference drained at w = 1.0
    cyc(1'b0, 2'd1, 1'b1, 24'h7FFF00, 0, 24'h000100, 0);
    cyc(1'b0, 2'd1, 1'b1, 24'h000000, 0, 24'h000100, 0);
    cyc(1'b0, 2'd2, 1'b1, 24'h000100, 0, 24'h000100, 0);
    chk("wrap_sum", dout_r, 24'h800000);
    cyc(1'b0, 2'd2, 1'b1, 24'h000000, 0, 24'h000100, 0);
    cyc(1'b0, 2'd1, 1'b0, 0, 0, 24'h000100, 0);
    chk("wrap_dif", dout_r, 24'h7FFE00);
    cyc(1'b0, 2'd1, 1'b0, 0, 0, 24'h000100, 0);

    // Reset on the first butterfly cycle of a burst
    cyc(1'b0, 2'd1, 1'b1, 24'h000500, 24'h000100, 24'h000100, 0);
    cyc(1'b0, 2'd1, 1'b1, 24'h000600, 24'h000200, 24'h000100, 0);
    cyc(1'b1, 2'd2, 1'b1, 24'h000700, 24'h000300, 24'h000100, 0);
    chk("mrst_v0", {23'd0, out_valid}, 24'd0);
    cyc(1'b0, 2'd1, 1'b1, 24'h000800, 0, 24'h000100, 0);
    chk("mrst_v1", {23'd0, out_valid}, 24'd0);
    cyc(1'b0, 2'd1, 1'b1, 24'h000900, 0, 24'h000100, 0);
    chk("mrst_v2", {23'd0, out_valid}, 24'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [1:0]         st;
      bit                 rst, iv;
      int                 sel;
      logic signed [23:0] dr, di, wr, wi;
      rst = ($urandom_range(0, 99) < 3);
      sel = $urandom_range(0, 9);
      st  = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd3 : (sel < 6) ? 2'd1 : 2'd2;
      iv  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 0) begin
        dr = 24'($signed($urandom_range(0, 8191)) - 4096);
        di = 24'($signed($urandom_range(0, 8191)) - 4096);
      end else begin
        dr = 24'($urandom);
        di = 24'($urandom);
      end
      wr = 24'($signed($urandom_range(0, 511)) - 256);
      wi = 24'($signed($urandom_range(0, 511)) - 256);
      cyc(rst, st, iv, dr, di, wr, wi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
